road_sequencer: RTL and testbench

- Owns the road-edge row memory for the stay-on-road game and schedules all access to it.
- Per frame it scrolls the road by the current speed and generates new rows with a bounded random curve.
- It arbitrates the single memory port between the pixel renderer (priority) and its own scroll and collision work.
- Runs the game state machine: init, play, dead, restart.

---
 rtl/road_pkg.sv | 34 +++
 rtl/road_curve_gen.sv | 50 +++++
 rtl/road_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_road_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_pkg.sv
// road_pkg: shared state encoding, geometry constants and LFSR helper for
// the stay-on-road sequencer.
package road_pkg;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      PLAY   = 3'd1,
      SCROLL = 3'd2,
      CHECK  = 3'd3,
      DEAD   = 3'd4
   } state_t;

   // Screen / road geometry (hCount units, screen rows)
   localparam int unsigned ROWS            = 480;
   localparam logic [8:0]  ROW_LAST        = 9'(ROWS - 1);
   localparam logic [9:0]  XCENTER         = 10'd464;
   localparam logic [9:0]  HALF_W          = 10'd50;
   localparam logic [9:0]  CMIN            = 10'd194;
   localparam logic [9:0]  CMAX            = 10'd734;
   localparam logic [10:0] CAR_HALF        = 11'd5;

   // Difficulty ramp
   localparam logic [4:0]  SPEED_INIT      = 5'd2;
   localparam logic [4:0]  SPEED_MAX       = 5'd16;
   localparam logic [9:0]  SPEED_UP_FRAMES = 10'd600;

   // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11
   localparam logic [15:0] LFSR_SEED       = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

endpackage

// File: rtl/road_curve_gen.sv
// road_curve_gen: free-running-on-enable LFSR that random-walks the road
// centre by -1/0/+1 per step, clamped to [CMIN, CMAX]. centre_nxt is the
// value the next enabled step will commit, so the caller can write it to
// memory in the same cycle.
module road_curve_gen
   import road_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   output logic [9:0] centre,
   output logic [9:0] centre_nxt
);

   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;
   logic [10:0] stepped;

   // Next LFSR value and clamped centre step derived from its low bits
   always_comb begin
      lfsr_nxt = lfsr_next(lfsr);
      stepped  = {1'b0, centre};
      case (lfsr_nxt[1:0])
         2'b00:   stepped = {1'b0, centre} - 11'd1;
         2'b01:   stepped = {1'b0, centre} + 11'd1;
         default: stepped = {1'b0, centre};
      endcase
      if (stepped < {1'b0, CMIN})
         centre_nxt = CMIN;
      else if (stepped > {1'b0, CMAX})
         centre_nxt = CMAX;
      else
         centre_nxt = stepped[9:0];
   end

   // LFSR and centre registers; load recentres without disturbing the LFSR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr   <= LFSR_SEED;
         centre <= XCENTER;
      end else if (load) begin
         centre <= XCENTER;
      end else if (en) begin
         lfsr   <= lfsr_nxt;
         centre <= centre_nxt;
      end
   end

endmodule

// File: rtl/road_sequencer.sv
// road_sequencer: owns the road-centre ring buffer, arbitrates its single
// port (renderer lookups first), scrolls/generates the road each frame and
// runs the game FSM. Optional macro COLLISION_GRACE_EN: a collision only
// kills when the previous checked frame also collided.
module road_sequencer
   import road_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        frame_tick,
   input  logic [9:0]  car_x,
   input  logic [8:0]  car_y,
   input  logic        ln_req,
   input  logic [8:0]  ln_row,
   output logic        ln_vld,
   output logic [9:0]  ln_left,
   output logic [9:0]  ln_right,
   output logic [2:0]  state,
   output logic        dead,
   output logic [15:0] score,
   output logic [4:0]  speed,
   output logic        overrun
);

   state_t      st;
   logic [8:0]  head;
   logic [8:0]  init_cnt;
   logic [4:0]  scroll_cnt;
   logic        chk_ph;
   logic [9:0]  car_x_q;
   logic [8:0]  car_y_q;
   logic [9:0]  frame_cnt;
`ifdef COLLISION_GRACE_EN
   logic        miss;
`endif

   logic [9:0]  mem [ROWS];
   logic [9:0]  rd_q;

   logic [8:0]  row_sel;
   logic [9:0]  rd_sum;
   logic [8:0]  rd_addr;
   logic [8:0]  head_dec;
   logic        init_step;
   logic        scroll_step;
   logic        we;
   logic        rd_en;
   logic [8:0]  wr_addr;
   logic [9:0]  wr_data;
   logic [9:0]  centre;
   logic [9:0]  centre_nxt;
   logic [9:0]  left_w;
   logic [9:0]  right_w;
   logic [10:0] car_w;
   logic        hit;
   logic        kill;

   road_curve_gen u_curve (
      .clk        (clk),
      .rst        (rst),
      .en         (scroll_step),
      .load       (st == INIT),
      .centre     (centre),
      .centre_nxt (centre_nxt)
   );

   // Port arbitration and address generation; renderer requests always win
   always_comb begin
      row_sel     = ln_req ? ln_row : car_y_q;
      rd_sum      = {1'b0, head} + {1'b0, row_sel};
      rd_addr     = (rd_sum >= 10'(ROWS)) ? 9'(rd_sum - 10'(ROWS)) : rd_sum[8:0];
      head_dec    = (head == '0) ? ROW_LAST : head - 9'd1;
      init_step   = (st == INIT) && !ln_req;
      scroll_step = (st == SCROLL) && !ln_req;
      we          = init_step || scroll_step;
      rd_en       = ln_req || ((st == CHECK) && !chk_ph);
      wr_addr     = init_step ? init_cnt : head_dec;
      wr_data     = init_step ? XCENTER : centre_nxt;
   end

   // Single-port ring buffer; write and read never coincide by construction
   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_q <= mem[rd_addr];
   end

   // Edge reconstruction, collision test and grace qualification
   always_comb begin
      left_w  = rd_q - HALF_W;
      right_w = rd_q + HALF_W;
      car_w   = {1'b0, car_x_q};
      hit     = (car_w < CAR_HALF) ||
                ((car_w - CAR_HALF) < {1'b0, left_w}) ||
                ((car_w + CAR_HALF) > {1'b0, right_w});
`ifdef COLLISION_GRACE_EN
      kill    = hit && miss;
`else
      kill    = hit;
`endif
   end

   assign ln_left  = ln_vld ? left_w  : '0;
   assign ln_right = ln_vld ? right_w : '0;
   assign state    = st;

   // Game FSM: init fill, idle play, scroll burst, two-phase check, dead
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= INIT;
         head       <= '0;
         init_cnt   <= '0;
         scroll_cnt <= '0;
         chk_ph     <= 1'b0;
         car_x_q    <= '0;
         car_y_q    <= '0;
         frame_cnt  <= '0;
         speed      <= SPEED_INIT;
         score      <= '0;
         dead       <= 1'b0;
         overrun    <= 1'b0;
         ln_vld     <= 1'b0;
`ifdef COLLISION_GRACE_EN
         miss       <= 1'b0;
`endif
      end else begin
         overrun <= 1'b0;
         ln_vld  <= ln_req;
         case (st)
            INIT: begin
               if (!ln_req) begin
                  if (init_cnt == ROW_LAST) begin
                     init_cnt <= '0;
                     st       <= PLAY;
                  end else begin
                     init_cnt <= init_cnt + 9'd1;
                  end
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  car_x_q    <= car_x;
                  car_y_q    <= car_y;
                  scroll_cnt <= speed;
                  st         <= SCROLL;
               end
            end
            SCROLL: begin
               if (frame_tick)
                  overrun <= 1'b1;
               if (!ln_req) begin
                  head       <= head_dec;
                  scroll_cnt <= scroll_cnt - 5'd1;
                  chk_ph     <= 1'b0;
                  if (scroll_cnt == 5'd1)
                     st <= CHECK;
               end
            end
            CHECK: begin
               if (frame_tick)
                  overrun <= 1'b1;
               // Phase 0 needs the port; phase 1 only consumes rd_q, so it
               // proceeds even while a renderer request is in flight.
               if (!chk_ph) begin
                  if (!ln_req)
                     chk_ph <= 1'b1;
               end else begin
                  chk_ph <= 1'b0;
`ifdef COLLISION_GRACE_EN
                  miss   <= hit;
`endif
                  if (kill) begin
                     st   <= DEAD;
                     dead <= 1'b1;
                  end else begin
                     st <= PLAY;
                     if (score != 16'hFFFF)
                        score <= score + 16'd1;
                     if (frame_cnt == SPEED_UP_FRAMES - 10'd1) begin
                        frame_cnt <= '0;
                        if (speed < SPEED_MAX)
                           speed <= speed + 5'd1;
                     end else begin
                        frame_cnt <= frame_cnt + 10'd1;
                     end
                  end
               end
            end
            DEAD: begin
               if (start) begin
                  st        <= INIT;
                  dead      <= 1'b0;
                  head      <= '0;
                  init_cnt  <= '0;
                  frame_cnt <= '0;
                  speed     <= SPEED_INIT;
                  score     <= '0;
`ifdef COLLISION_GRACE_EN
                  miss      <= 1'b0;
`endif
               end
            end
            default: st <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_road_sequencer.sv
// tb_road_sequencer: randomized self-checking bench for road_sequencer.
// The reference model keeps the visible road as a queue of centres indexed
// by screen row; each scroll pushes a new centre at the top.
module tb_road_sequencer;
   import road_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        frame_tick = 1'b0;
   logic [9:0]  car_x = '0;
   logic [8:0]  car_y = '0;
   logic        ln_req = 1'b0;
   logic [8:0]  ln_row = '0;
   logic        ln_vld;
   logic [9:0]  ln_left;
   logic [9:0]  ln_right;
   logic [2:0]  state;
   logic        dead;
   logic [15:0] score;
   logic [4:0]  speed;
   logic        overrun;

   int checks = 0;
   int passed = 0;

   // Reference model state
   int          cen[$];
   int          mcen;
   logic [15:0] mlfsr;
   int          mspeed;
   int          mscore;
   bit          mmiss;

   road_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .frame_tick (frame_tick),
      .car_x      (car_x),
      .car_y      (car_y),
      .ln_req     (ln_req),
      .ln_row     (ln_row),
      .ln_vld     (ln_vld),
      .ln_left    (ln_left),
      .ln_right   (ln_right),
      .state      (state),
      .dead       (dead),
      .score      (score),
      .speed      (speed),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, checks);
      $fatal(1);
   end

   function automatic void model_fill();
      cen.delete();
      for (int i = 0; i < 480; i++) cen.push_back(464);
      mcen   = 464;
      mspeed = 2;
      mscore = 0;
      mmiss  = 1'b0;
   endfunction

   function automatic void model_reset();
      mlfsr = 16'hACE1;
      model_fill();
   endfunction

   // Scroll mspeed rows, then judge the car; returns 1 when the frame kills
   function automatic bit model_frame(input int cx, input int cy);
      bit hit;
      bit kill;
      for (int s = 0; s < mspeed; s++) begin
         mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
         if (mlfsr[1:0] == 2'b00) mcen = mcen - 1;
         else if (mlfsr[1:0] == 2'b01) mcen = mcen + 1;
         if (mcen < 194) mcen = 194;
         if (mcen > 734) mcen = 734;
         cen.push_front(mcen);
         void'(cen.pop_back());
      end
      hit = (cx - 5 < cen[cy] - 50) || (cx + 5 > cen[cy] + 50);
`ifdef COLLISION_GRACE_EN
      kill  = hit && mmiss;
      mmiss = hit;
`else
      kill  = hit;
`endif
      if (!kill) begin
         if (mscore < 65535) mscore++;
         mspeed = 2 + mscore / 600;
         if (mspeed > 16) mspeed = 16;
      end
      return kill;
   endfunction

   task automatic wait_settle();
      int n;
      n = 0;
      while (state != 3'(PLAY) && state != 3'(DEAD) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 60) $display("FAIL settle: state=%0d after %0d cycles, required PLAY or DEAD", state, n);
      else passed++;
   endtask

   task automatic lookup(input int r, input string tag);
      @(negedge clk);
      ln_req = 1'b1;
      ln_row = r[8:0];
      @(negedge clk);
      ln_req = 1'b0;
      checks++;
      if (ln_vld !== 1'b1 || ln_left !== 10'(cen[r] - 50) || ln_right !== 10'(cen[r] + 50))
         $display("FAIL %s row %0d: vld=%b left=%0d right=%0d, required vld=1 left=%0d right=%0d",
                  tag, r, ln_vld, ln_left, ln_right, cen[r] - 50, cen[r] + 50);
      else passed++;
   endtask

   task automatic check_frame_result(input bit exp_dead, input string tag);
      checks++;
      if (dead !== exp_dead || state !== (exp_dead ? 3'(DEAD) : 3'(PLAY)))
         $display("FAIL %s dead/state: dead=%b state=%0d, required dead=%b", tag, dead, state, exp_dead);
      else passed++;
      checks++;
      if (score !== 16'(mscore)) $display("FAIL %s score: got %0d required %0d", tag, score, mscore);
      else passed++;
      checks++;
      if (speed !== 5'(mspeed)) $display("FAIL %s speed: got %0d required %0d", tag, speed, mspeed);
      else passed++;
   endtask

   task automatic run_frame(input int cx, input int cy, input string tag);
      bit exp_dead;
      @(negedge clk);
      car_x      = cx[9:0];
      car_y      = cy[8:0];
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      wait_settle();
      exp_dead = model_frame(cx, cy);
      check_frame_result(exp_dead, tag);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ln_req = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (state !== 3'(INIT) || dead !== 1'b0 || ln_vld !== 1'b0 || ln_left !== 10'd0 ||
          ln_right !== 10'd0 || score !== 16'd0 || speed !== 5'd2 || overrun !== 1'b0)
         $display("FAIL reset: state=%0d dead=%b vld=%b left=%0d right=%0d score=%0d speed=%0d ovr=%b, required 0/0/0/0/0/0/2/0",
                  state, dead, ln_vld, ln_left, ln_right, score, speed, overrun);
      else passed++;
      ln_req = 1'b0;
   endtask

   task automatic test_init_fill();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (ROWS + 2) @(negedge clk);
      checks++;
      if (state !== 3'(PLAY)) $display("FAIL init_done: state=%0d required %0d", state, PLAY);
      else passed++;
      lookup(0, "init_row");
      lookup(479, "init_row");
      for (int i = 0; i < 3; i++) lookup($urandom_range(1, 478), "init_row");
   endtask

   task automatic test_first_frame();
      run_frame(464, 175, "first_frame");
      lookup(0, "first_rows");
      lookup(1, "first_rows");
      lookup(2, "first_rows");
      lookup(479, "first_rows");
   endtask

   task automatic test_stall();
      int r;
      int prev;
      bit exp_dead;
      @(negedge clk);
      car_y      = 9'd200;
      car_x      = 10'(cen[200 - mspeed]);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      prev   = $urandom_range(0, 479);
      ln_req = 1'b1;
      ln_row = prev[8:0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (state !== 3'(SCROLL) || ln_vld !== 1'b1 || ln_left !== 10'(cen[prev] - 50))
            $display("FAIL stall cycle %0d: state=%0d vld=%b left=%0d, required state=%0d vld=1 left=%0d",
                     i, state, ln_vld, ln_left, SCROLL, cen[prev] - 50);
         else passed++;
         r      = $urandom_range(0, 479);
         prev   = r;
         ln_row = r[8:0];
         if (i == 9) ln_req = 1'b0;
      end
      wait_settle();
      exp_dead = model_frame(int'(car_x), 200);
      check_frame_result(exp_dead, "stall_frame");
      lookup(0, "stall_rows");
      lookup($urandom_range(1, 479), "stall_rows");
   endtask

   task automatic test_overrun();
      bit exp_dead;
      @(negedge clk);
      car_y      = 9'd300;
      car_x      = 10'(cen[300 - mspeed]);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      checks++;
      if (overrun !== 1'b1) $display("FAIL overrun pulse: got %b required 1", overrun);
      else passed++;
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0) $display("FAIL overrun width: got %b required 0", overrun);
      else passed++;
      wait_settle();
      exp_dead = model_frame(int'(car_x), 300);
      check_frame_result(exp_dead, "overrun_frame");
      lookup(0, "overrun_rows");
      lookup(mspeed, "overrun_rows");
   endtask

   task automatic test_collision();
      int cy;
      int cx;
      int base;
      bit exp_dead;
      cy = $urandom_range(20, 470);
      run_frame(cen[cy - mspeed] + 45, cy, "edge_right_clean");
      run_frame(cen[cy - mspeed] - 45, cy, "edge_left_clean");
      exp_dead = 1'b0;
      for (int k = 0; k < 3 && !exp_dead; k++) begin
         base = cen[cy - mspeed];
         cx   = (k % 2 == 0) ? base + 46 : base - 46;
         @(negedge clk);
         car_x      = cx[9:0];
         car_y      = cy[8:0];
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         wait_settle();
         exp_dead = model_frame(cx, cy);
         check_frame_result(exp_dead, "edge_hit");
      end
      checks++;
      if (dead !== 1'b1) $display("FAIL collision_dead: dead=%b required 1", dead);
      else passed++;
   endtask

   task automatic test_dead_restart();
      int r;
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (state !== 3'(DEAD) || score !== 16'(mscore))
         $display("FAIL dead_frozen: state=%0d score=%0d, required state=%0d score=%0d", state, score, DEAD, mscore);
      else passed++;
      r = $urandom_range(0, 479);
      lookup(r, "dead_lookup");
      @(negedge clk);
      start      = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      frame_tick = 1'b0;
      checks++;
      if (state !== 3'(INIT) || score !== 16'd0 || speed !== 5'd2 || dead !== 1'b0)
         $display("FAIL restart: state=%0d score=%0d speed=%0d dead=%b, required INIT 0 2 0", state, score, speed, dead);
      else passed++;
      model_fill();
      repeat (ROWS + 2) @(negedge clk);
      checks++;
      if (state !== 3'(PLAY)) $display("FAIL restart_play: state=%0d required %0d", state, PLAY);
      else passed++;
      lookup(0, "restart_rows");
      lookup($urandom_range(1, 479), "restart_rows");
   endtask

   task automatic test_speedup();
      int cy;
      int cx;
      int n;
      n = 0;
      while (mscore < 601 && n < 700) begin
         cy = $urandom_range(20, 479);
         cx = cen[cy - mspeed] + $urandom_range(0, 80) - 40;
         run_frame(cx, cy, "speedup_frame");
         if (n % 16 == 0) lookup($urandom_range(0, 479), "speedup_rows");
         n++;
      end
      checks++;
      if (speed !== 5'd3) $display("FAIL speedup: speed=%0d required 3", speed);
      else passed++;
   endtask

   task automatic test_reset_mid_scroll();
      @(negedge clk);
      car_y      = 9'd100;
      car_x      = 10'(cen[100]);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      ln_req     = 1'b1;
      ln_row     = 9'd5;
      @(posedge clk);
      #1;
      checks++;
      if (ln_vld !== 1'b1 || state !== 3'(SCROLL))
         $display("FAIL pre_reset: vld=%b state=%0d, required vld=1 state=%0d", ln_vld, state, SCROLL);
      else passed++;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (state !== 3'(INIT) || ln_vld !== 1'b0 || ln_left !== 10'd0 || score !== 16'd0 || speed !== 5'd2)
         $display("FAIL mid_reset: state=%0d vld=%b left=%0d score=%0d speed=%0d, required INIT 0 0 0 2",
                  state, ln_vld, ln_left, score, speed);
      else passed++;
      @(negedge clk);
      ln_req = 1'b0;
      rst    = 1'b1;
      model_reset();
      repeat (ROWS + 2) @(negedge clk);
      checks++;
      if (state !== 3'(PLAY)) $display("FAIL mid_reset_play: state=%0d required %0d", state, PLAY);
      else passed++;
      run_frame(464, 175, "post_reset_frame");
      lookup(0, "post_reset_rows");
      lookup(1, "post_reset_rows");
   endtask

   initial begin
      test_reset();
      test_init_fill();
      test_first_frame();
      test_stall();
      test_overrun();
      test_collision();
      test_dead_restart();
      test_speedup();
      test_reset_mid_scroll();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
